// File: rtl/kgp_pkg.sv
// kgp_pkg: KGP-RISC datapath constants shared by the register file, ALU and control unit
package kgp_pkg;
    localparam int KGP_DATA_W  = 32;
    localparam int KGP_NREGS   = 32;
    localparam int KGP_ADDR_W  = 5;
    localparam int KGP_PAIR_LO = 19;
    localparam int KGP_PAIR_HI = 20;

    function automatic bit is_pair(input int idx, input int lo, input int hi);
        return idx == lo || idx == hi;
    endfunction
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port with write bypass, r0 masking and busy gating
module regfile_rdport import kgp_pkg::*; #(
    parameter int DATA_W  = KGP_DATA_W,
    parameter int NREGS   = KGP_NREGS,
    parameter int ADDR_W  = KGP_ADDR_W,
    parameter int PAIR_LO = KGP_PAIR_LO,
    parameter int PAIR_HI = KGP_PAIR_HI,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] regs [NREGS],
    input  logic [NREGS-1:0]  busy,
    input  logic              wren,
    input  logic              wpair,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);
    localparam logic [ADDR_W-1:0] LO = ADDR_W'(PAIR_LO);
    localparam logic [ADDR_W-1:0] HI = ADDR_W'(PAIR_HI);

    logic is_r0;
    logic hit;
    logic fwd;

    always_comb begin
        is_r0 = ZERO_R0 != 0 && raddr == '0;
        hit   = wpair ? (raddr == LO || raddr == HI) : raddr == waddr;
        fwd   = BYPASS != 0 && wren && hit && !is_r0;
        rdata = is_r0 ? '0 : fwd ? ((wpair && raddr == HI) ? wdata1 : wdata0) : regs[raddr];
        rbusy = fwd ? 1'b0 : busy[raddr];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with paired lo/hi write, bypass and busy scoreboard
module regfile_mp import kgp_pkg::*; #(
    parameter int DATA_W  = KGP_DATA_W,
    parameter int NREGS   = KGP_NREGS,
    parameter int ADDR_W  = KGP_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter int PAIR_LO = KGP_PAIR_LO,
    parameter int PAIR_HI = KGP_PAIR_HI,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     wren,
    input  logic                     wpair,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     sb_set,
    input  logic                     sb_pair,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic                     any_busy
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  wr_hit;
    logic [NREGS-1:0]  sb_hit;

    // r0 is excluded from both decodes so it never stores data nor goes busy
    for (genvar i = 0; i < NREGS; i++) begin : g_dec
        localparam bit KEEP = !(ZERO_R0 != 0 && i == 0);
        localparam bit PAIR = is_pair(i, PAIR_LO, PAIR_HI);
        assign wr_hit[i] = KEEP && wren && (wpair ? PAIR : waddr == ADDR_W'(i));
        assign sb_hit[i] = KEEP && sb_set && (sb_pair ? PAIR : sb_addr == ADDR_W'(i));
    end

    // set wins over a same-cycle clearing write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int j = 0; j < NREGS; j++) regs[j] <= '0;
        end else begin
            busy <= sb_hit | (busy & ~wr_hit);
            for (int j = 0; j < NREGS; j++)
                if (wr_hit[j]) regs[j] <= (wpair && j == PAIR_HI) ? wdata1 : wdata0;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rdport #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .ADDR_W (ADDR_W),
            .PAIR_LO(PAIR_LO),
            .PAIR_HI(PAIR_HI),
            .ZERO_R0(ZERO_R0),
            .BYPASS (BYPASS)
        ) u_port (
            .raddr (raddr[k*ADDR_W +: ADDR_W]),
            .regs  (regs),
            .busy  (busy),
            .wren  (wren),
            .wpair (wpair),
            .waddr (waddr),
            .wdata0(wdata0),
            .wdata1(wdata1),
            .rdata (rdata[k*DATA_W +: DATA_W]),
            .rbusy (rbusy[k])
        );
    end

    assign any_busy = |busy;
endmodule
